mapper_ss_xfer: RTL and testbench

Savestate initiator for the cartridge mapper savestate bus.
- Save: captures the active mapper's 64-bit savestate_back word and writes it to savestate memory as sequential beats.
- Load: reads the beats back, assembles the 64-bit word and presents it on savestate_data with a single-cycle savestate_load strobe.
- Sits between the top-level savestate controller and the shared mapper savestate bus, next to the cart block.

---
 rtl/mapper_ss_pkg.sv | 26 ++
 rtl/mapper_ss_beat_ctr.sv | 41 ++++
 rtl/mapper_ss_xfer.sv | 226 ++++++++++++++++++++++
 tb/tb_mapper_ss_xfer.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mapper_ss_pkg.sv
// mapper_ss_pkg
//   Shared definitions for the mapper savestate transfer block.
//   - SS_W       : width of the mapper savestate word
//   - CHECK_SEED : constant folded into the optional check beat
//   - ss_state_t : transfer FSM states
//   - ss_beats() : number of memory beats per savestate word
package mapper_ss_pkg;

  localparam int SS_W = 64;

  localparam logic [SS_W-1:0] CHECK_SEED = 64'hA5A5_A5A5_A5A5_A5A5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SAVE_CAP,
    ST_SAVE_WR,
    ST_LOAD_RD,
    ST_LOAD_APPLY,
    ST_FIN
  } ss_state_t;

  function automatic int ss_beats(input int data_w);
    return SS_W / data_w;
  endfunction

endpackage

// File: rtl/mapper_ss_beat_ctr.sv
// mapper_ss_beat_ctr
//   Beat counter shared by the save and load paths. Produces the memory
//   address of the current beat and flags the final beat of a transfer.
//   Ports:
//     clk_sys, reset_n : clock, asynchronous active-low reset
//     clear            : operation start, counter back to 0
//     step             : current beat acknowledged
//     cnt              : current beat index
//     addr             : BASE_ADDR + cnt
//     last             : current beat is the final one of the transfer
module mapper_ss_beat_ctr #(
  parameter int                ADDR_W    = 25,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                TOTAL     = 4,
  parameter int                CW        = 3
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              step,
  output logic [CW-1:0]     cnt,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  assign last = (cnt == CW'(TOTAL - 1));
  assign addr = BASE_ADDR + ADDR_W'(cnt);

  // Wrapping on the final ack keeps the index inside the transfer window
  // even while the FSM sits in FIN/IDLE.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (step) begin
      cnt <= last ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mapper_ss_xfer.sv
// mapper_ss_xfer
//   Savestate initiator for the cartridge mapper savestate bus.
//   Save: captures savestate_back and writes it to memory beat by beat,
//   least-significant beat first. Load: reads the beats back, assembles
//   the word and presents it on savestate_data with a one-cycle
//   savestate_load strobe.
//   Ports:
//     clk_sys, reset_n      : clock, asynchronous active-low reset
//     save_req, load_req    : start pulses, sampled in IDLE only
//     busy, done, error     : status (error sticky until next request)
//     savestate_back        : mapper state from the shared bus
//     savestate_load/_data  : apply strobe and registered state word
//     mem_req/we/addr/wdata : beat request towards savestate memory
//     mem_rdata, mem_ack    : read data and beat acknowledge
//   Optional build macro MAPPER_SS_XFER_CHECK_EN adds a check beat after
//   the data beats (XOR of data beats with CHECK_SEED); a failing check on
//   load sets error and suppresses the apply.
module mapper_ss_xfer
  import mapper_ss_pkg::*;
#(
  parameter int                DATA_W    = 16,
  parameter int                ADDR_W    = 25,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              save_req,
  input  logic              load_req,
  output logic              busy,
  output logic              done,
  output logic              error,
  input  logic [SS_W-1:0]   savestate_back,
  output logic              savestate_load,
  output logic [SS_W-1:0]   savestate_data,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  localparam int BEATS = ss_beats(DATA_W);
`ifdef MAPPER_SS_XFER_CHECK_EN
  localparam int CHK_BEATS = 1;
`else
  localparam int CHK_BEATS = 0;
`endif
  localparam int TOTAL = BEATS + CHK_BEATS;
  localparam int CW    = $clog2(BEATS) + 1;

  ss_state_t         state_q, state_d;
  logic [SS_W-1:0]   shadow_q;
  logic [SS_W-1:0]   asm_q;
  logic [SS_W-1:0]   asm_next;
  logic [DATA_W-1:0] wdata_beat;
  logic [CW-1:0]     beat_cnt;
  logic [ADDR_W-1:0] beat_addr;
  logic              beat_last;
  logic              beat_step;
  logic              op_start;
  logic              in_xfer;
  logic              check_ok;
  logic              load_finish;

  assign op_start    = (state_q == ST_IDLE) && (save_req || load_req);
  assign beat_step   = mem_req && mem_ack;
  assign in_xfer     = (state_q == ST_SAVE_WR) || (state_q == ST_LOAD_RD);
  assign load_finish = (state_q == ST_LOAD_RD) && beat_step && beat_last;

  mapper_ss_beat_ctr #(
    .ADDR_W    (ADDR_W),
    .BASE_ADDR (BASE_ADDR),
    .TOTAL     (TOTAL),
    .CW        (CW)
  ) u_beat_ctr (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .clear   (op_start),
    .step    (beat_step),
    .cnt     (beat_cnt),
    .addr    (beat_addr),
    .last    (beat_last)
  );

`ifdef MAPPER_SS_XFER_CHECK_EN
  function automatic logic [DATA_W-1:0] check_word(input logic [SS_W-1:0] w);
    logic [DATA_W-1:0] acc;
    acc = CHECK_SEED[DATA_W-1:0];
    for (int k = 0; k < BEATS; k++) begin
      acc = acc ^ w[k*DATA_W +: DATA_W];
    end
    return acc;
  endfunction

  // The check beat arrives after every data beat, so asm_q is complete.
  assign check_ok = (mem_rdata == check_word(asm_q));

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      error <= 1'b0;
    end else if (op_start) begin
      error <= 1'b0;
    end else if (load_finish && !check_ok) begin
      error <= 1'b1;
    end
  end
`else
  assign check_ok = 1'b1;
  assign error    = 1'b0;
`endif

  // Write data for the current beat; the beat past the data beats (only
  // present with the check feature) carries the check word.
  always_comb begin
`ifdef MAPPER_SS_XFER_CHECK_EN
    wdata_beat = check_word(shadow_q);
`else
    wdata_beat = '0;
`endif
    for (int k = 0; k < BEATS; k++) begin
      if (beat_cnt == CW'(k)) begin
        wdata_beat = shadow_q[k*DATA_W +: DATA_W];
      end
    end
  end

  // Assembly word including the beat being acknowledged right now, so the
  // final data beat can go straight into savestate_data.
  always_comb begin
    asm_next = asm_q;
    for (int k = 0; k < BEATS; k++) begin
      if (beat_cnt == CW'(k)) begin
        asm_next[k*DATA_W +: DATA_W] = mem_rdata;
      end
    end
  end

  assign mem_addr  = mem_req ? beat_addr : '0;
  assign mem_wdata = (mem_req && (state_q == ST_SAVE_WR)) ? wdata_beat : '0;

  // State register.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and status decode. busy drops in FIN together with done.
  always_comb begin
    state_d        = state_q;
    busy           = 1'b0;
    done           = 1'b0;
    savestate_load = 1'b0;
    mem_we         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (save_req) begin
          state_d = ST_SAVE_CAP;
        end else if (load_req) begin
          state_d = ST_LOAD_RD;
        end
      end
      ST_SAVE_CAP: begin
        busy    = 1'b1;
        state_d = ST_SAVE_WR;
      end
      ST_SAVE_WR: begin
        busy   = 1'b1;
        mem_we = mem_req;
        if (beat_step && beat_last) begin
          state_d = ST_FIN;
        end
      end
      ST_LOAD_RD: begin
        busy = 1'b1;
        if (load_finish) begin
          state_d = check_ok ? ST_LOAD_APPLY : ST_FIN;
        end
      end
      ST_LOAD_APPLY: begin
        busy           = 1'b1;
        savestate_load = 1'b1;
        state_d        = ST_FIN;
      end
      ST_FIN: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Datapath: shadow capture, request handshake, load assembly. mem_req
  // rises one cycle into a transfer and falls the cycle after the last ack.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      shadow_q       <= '0;
      asm_q          <= '0;
      savestate_data <= '0;
      mem_req        <= 1'b0;
    end else begin
      if (state_q == ST_SAVE_CAP) begin
        shadow_q <= savestate_back;
      end
      if (op_start) begin
        asm_q <= '0;
      end else if ((state_q == ST_LOAD_RD) && beat_step) begin
        asm_q <= asm_next;
      end
      if (load_finish && check_ok) begin
        savestate_data <= asm_next;
      end
      if (beat_step && beat_last) begin
        mem_req <= 1'b0;
      end else if (in_xfer) begin
        mem_req <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mapper_ss_xfer.sv
// tb_mapper_ss_xfer
//   Scoreboard bench for mapper_ss_xfer (DATA_W=16, BASE_ADDR=0).
//   Stimulus pushes expected memory beats, load words and done events into
//   queues; a memory responder and an output monitor pop and compare them.
//   Honours MAPPER_SS_XFER_CHECK_EN like the design.
module tb_mapper_ss_xfer;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 25;
  localparam int BEATS  = 64 / DATA_W;
`ifdef MAPPER_SS_XFER_CHECK_EN
  localparam int CHK = 1;
`else
  localparam int CHK = 0;
`endif
  localparam int TOTAL = BEATS + CHK;

  typedef struct {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } beat_t;

  logic              clk_sys = 1'b0;
  logic              reset_n;
  logic              save_req;
  logic              load_req;
  logic              busy;
  logic              done;
  logic              error;
  logic [63:0]       savestate_back;
  logic              savestate_load;
  logic [63:0]       savestate_data;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  int n_cmp  = 0;
  int n_fail = 0;

  beat_t       exp_beat_q[$];
  logic [63:0] exp_load_q[$];
  bit          exp_done_q[$];

  logic [DATA_W-1:0] mem       [0:15];
  logic [DATA_W-1:0] model_mem [0:15];
  logic [63:0]       ref_data;

  int ack_min    = 0;
  int ack_max    = 0;
  bit spurious   = 1'b0;
  int acks_given = 0;

  always #5 clk_sys = ~clk_sys;

  mapper_ss_xfer #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .BASE_ADDR ('0)
  ) dut (
    .clk_sys        (clk_sys),
    .reset_n        (reset_n),
    .save_req       (save_req),
    .load_req       (load_req),
    .busy           (busy),
    .done           (done),
    .error          (error),
    .savestate_back (savestate_back),
    .savestate_load (savestate_load),
    .savestate_data (savestate_data),
    .mem_req        (mem_req),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata),
    .mem_ack        (mem_ack)
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference check word: XOR of the 16-bit pieces of the word and A5A5.
  function automatic logic [DATA_W-1:0] model_check(input logic [63:0] w);
    logic [DATA_W-1:0] acc;
    acc = 16'hA5A5;
    for (int k = 0; k < BEATS; k++) acc = acc ^ DATA_W'(w >> (DATA_W * k));
    return acc;
  endfunction

  function automatic logic [63:0] model_image();
    logic [63:0] w;
    w = '0;
    for (int k = 0; k < BEATS; k++) w = w | (64'(model_mem[k]) << (DATA_W * k));
    return w;
  endfunction

  task automatic preload(input logic [63:0] word);
    for (int k = 0; k < BEATS; k++) begin
      mem[k]       = DATA_W'(word >> (DATA_W * k));
      model_mem[k] = DATA_W'(word >> (DATA_W * k));
    end
    if (CHK == 1) begin
      mem[BEATS]       = model_check(word);
      model_mem[BEATS] = model_check(word);
    end
  endtask

  // Issue one request and follow it to done. scramble disturbs
  // savestate_back right after capture; inject_at pulses a load_req while busy.
  task automatic applyStimulus(input bit do_save, input bit do_load, input logic [63:0] word,
                               input bit scramble, input int inject_at);
    int          exp_lat;
    int          exp_ld_cyc;
    int          cyc;
    bit          seen;
    bit          zero;
    bit          ok;
    logic [63:0] w;
    beat_t       b;
    zero       = (ack_max == 0);
    exp_ld_cyc = -1;
    if (do_save) begin
      for (int k = 0; k < BEATS; k++) model_mem[k] = DATA_W'(word >> (DATA_W * k));
      if (CHK == 1) model_mem[BEATS] = model_check(word);
      for (int k = 0; k < TOTAL; k++) begin
        b.we = 1'b1; b.addr = ADDR_W'(k); b.data = model_mem[k];
        exp_beat_q.push_back(b);
      end
      exp_done_q.push_back(1'b0);
      exp_lat = TOTAL + 3;
    end else begin
      for (int k = 0; k < TOTAL; k++) begin
        b.we = 1'b0; b.addr = ADDR_W'(k); b.data = '0;
        exp_beat_q.push_back(b);
      end
      w  = model_image();
      ok = (CHK == 0) || (model_check(w) == model_mem[BEATS]);
      if (ok) begin
        exp_load_q.push_back(w);
        exp_done_q.push_back(1'b0);
        exp_ld_cyc = TOTAL + 2;
        exp_lat    = TOTAL + 3;
      end else begin
        exp_done_q.push_back(1'b1);
        exp_lat = TOTAL + 2;
      end
    end
    @(posedge clk_sys); #1;
    save_req       = do_save;
    load_req       = do_load;
    savestate_back = do_save ? word : {$urandom, $urandom};
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 300) begin
      @(posedge clk_sys); #1;
      cyc++;
      if (cyc == 1) begin
        save_req = 1'b0;
        load_req = 1'b0;
        checkOutput("error_cleared", 64'(error), 64'd0);
      end
      if (cyc == 2 && scramble) savestate_back = ($urandom_range(1, 0) == 0) ? 64'd0 : {$urandom, $urandom};
      if (cyc == inject_at) load_req = 1'b1;
      if (cyc == inject_at + 1) load_req = 1'b0;
      if (savestate_load && zero && exp_ld_cyc >= 0) checkOutput("load_cycle", 64'(cyc), 64'(exp_ld_cyc));
      if (done) begin
        seen = 1'b1;
        checkOutput("busy_at_done", 64'(busy), 64'd0);
        if (zero) checkOutput("done_latency", 64'(cyc), 64'(exp_lat));
      end else begin
        checkOutput("busy_during_op", 64'(busy), 64'd1);
      end
    end
    if (!seen) begin
      n_cmp++;
      n_fail++;
      $display("[TB] FAIL done_timeout: got no done after %0d cycles expected done", cyc);
    end
    save_req = 1'b0;
    load_req = 1'b0;
  endtask

  task automatic idleCheck(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_sys); #1;
      checkOutput("idle_busy", 64'(busy), 64'd0);
      checkOutput("idle_mem_req", 64'(mem_req), 64'd0);
    end
  endtask

  task automatic resetMidLoad();
    beat_t b;
    int    start;
    int    cnt;
    for (int k = 0; k < TOTAL; k++) begin
      b.we = 1'b0; b.addr = ADDR_W'(k); b.data = '0;
      exp_beat_q.push_back(b);
    end
    @(posedge clk_sys); #1;
    load_req = 1'b1;
    @(posedge clk_sys); #1;
    load_req = 1'b0;
    start = acks_given;
    cnt   = 0;
    while (acks_given == start && cnt < 100) begin
      @(posedge clk_sys); #1;
      cnt++;
    end
    checkOutput("first_beat_acked", 64'(acks_given - start), 64'd1);
    reset_n  = 1'b0;
    ref_data = '0;
    exp_beat_q.delete();
    exp_load_q.delete();
    exp_done_q.delete();
    repeat (2) @(posedge clk_sys);
    #1;
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_done", 64'(done), 64'd0);
    checkOutput("rst_load", 64'(savestate_load), 64'd0);
    checkOutput("rst_data", savestate_data, 64'd0);
    checkOutput("rst_mem_req", 64'(mem_req), 64'd0);
    reset_n = 1'b1;
    idleCheck(4);
  endtask

  // Memory responder and beat scoreboard.
  initial begin
    logic [ADDR_W+DATA_W:0] held;
    bit                     waiting;
    int                     wait_left;
    int                     idx;
    beat_t                  e;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    waiting   = 1'b0;
    wait_left = 0;
    forever begin
      @(negedge clk_sys);
      if (!reset_n) begin
        mem_ack = 1'b0;
        waiting = 1'b0;
      end else begin
        if (mem_ack) begin
          mem_ack = 1'b0;
          waiting = 1'b0;
        end
        mem_rdata = DATA_W'($urandom);
        if (mem_req) begin
          if (!waiting) begin
            waiting   = 1'b1;
            wait_left = $urandom_range(ack_max, ack_min);
            held      = {mem_we, mem_addr, mem_wdata};
          end else begin
            checkOutput("beat_stable", 64'({mem_we, mem_addr, mem_wdata}), 64'(held));
          end
          if (wait_left == 0) begin
            mem_ack = 1'b1;
            acks_given++;
            idx = int'(mem_addr[3:0]);
            if (exp_beat_q.size() == 0) begin
              n_cmp++;
              n_fail++;
              $display("[TB] FAIL unexpected_beat: got addr %h we %b expected no beat", mem_addr, mem_we);
            end else begin
              e = exp_beat_q.pop_front();
              checkOutput("beat_we", 64'(mem_we), 64'(e.we));
              checkOutput("beat_addr", 64'(mem_addr), 64'(e.addr));
              if (e.we) checkOutput("beat_wdata", 64'(mem_wdata), 64'(e.data));
            end
            if (mem_we) mem[idx] = mem_wdata;
            else mem_rdata = mem[idx];
          end else begin
            wait_left--;
          end
        end else if (spurious && $urandom_range(3, 0) == 0) begin
          mem_ack = 1'b1;
        end
      end
    end
  end

  // Output monitor: apply strobes, done pulses and the held state word.
  initial begin
    logic [63:0] w;
    bit          e;
    ref_data = '0;
    forever begin
      @(negedge clk_sys);
      if (savestate_load) begin
        if (exp_load_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("[TB] FAIL unexpected_load: got savestate_load data %h expected none", savestate_data);
        end else begin
          w = exp_load_q.pop_front();
          ref_data = w;
        end
      end
      checkOutput("savestate_data", savestate_data, ref_data);
      if (done) begin
        if (exp_done_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("[TB] FAIL unexpected_done: got done expected none");
        end else begin
          e = exp_done_q.pop_front();
          checkOutput("done_error", 64'(error), 64'(e));
        end
      end
    end
  end

  initial begin
    int          op;
    logic [63:0] word;
    reset_n        = 1'b0;
    save_req       = 1'b0;
    load_req       = 1'b0;
    savestate_back = '0;
    for (int i = 0; i < 16; i++) begin
      mem[i]       = '0;
      model_mem[i] = '0;
    end
    repeat (3) @(posedge clk_sys);
    #1;
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_done", 64'(done), 64'd0);
    checkOutput("reset_error", 64'(error), 64'd0);
    checkOutput("reset_load", 64'(savestate_load), 64'd0);
    checkOutput("reset_data", savestate_data, 64'd0);
    checkOutput("reset_mem_req", 64'(mem_req), 64'd0);
    checkOutput("reset_mem_we", 64'(mem_we), 64'd0);
    checkOutput("reset_mem_addr", 64'(mem_addr), 64'd0);
    checkOutput("reset_mem_wdata", 64'(mem_wdata), 64'd0);
    reset_n = 1'b1;
    idleCheck(2);

    $display("[TB] directed save, zero-wait ack");
    ack_min = 0; ack_max = 0; spurious = 1'b0;
    applyStimulus(1'b1, 1'b0, 64'h0123_4567_89AB_CDEF, 1'b0, -1);
    checkOutput("mem_beat0", 64'(mem[0]), 64'hCDEF);
    checkOutput("mem_beat3", 64'(mem[3]), 64'h0123);
    idleCheck(2);

    $display("[TB] directed load, 3-cycle ack delay");
    preload(64'h0123_4567_89AB_CDEF);
    ack_min = 3; ack_max = 3;
    applyStimulus(1'b0, 1'b1, 64'd0, 1'b0, -1);
    idleCheck(4);

    $display("[TB] simultaneous requests and a dropped load_req");
    ack_min = 0; ack_max = 2;
    applyStimulus(1'b1, 1'b1, 64'hFEDC_BA98_7654_3210, 1'b0, 3);
    idleCheck(4);

    $display("[TB] savestate_back changes after capture");
    ack_min = 0; ack_max = 0;
    savestate_back = '0;
    applyStimulus(1'b1, 1'b0, 64'h1357_9BDF_2468_ACE0, 1'b1, -1);
    applyStimulus(1'b0, 1'b1, 64'd0, 1'b0, -1);
    idleCheck(2);

    $display("[TB] reset during load");
    ack_min = 1; ack_max = 1;
    resetMidLoad();
    ack_min = 0; ack_max = 0;
    applyStimulus(1'b0, 1'b1, 64'd0, 1'b0, -1);
    idleCheck(2);

`ifdef MAPPER_SS_XFER_CHECK_EN
    $display("[TB] corrupted beat 2 detected by check beat");
    mem[2]       = mem[2] ^ 16'h0040;
    model_mem[2] = model_mem[2] ^ 16'h0040;
    applyStimulus(1'b0, 1'b1, 64'd0, 1'b0, -1);
    checkOutput("error_sticky", 64'(error), 64'd1);
    applyStimulus(1'b1, 1'b0, 64'h0BAD_F00D_CAFE_BEEF, 1'b0, -1);
`else
    $display("[TB] load without check beat, error stays low");
    applyStimulus(1'b0, 1'b1, 64'd0, 1'b0, -1);
    checkOutput("error_low", 64'(error), 64'd0);
`endif
    idleCheck(2);

    $display("[TB] randomized operations");
    spurious = 1'b1;
    for (int i = 0; i < 40; i++) begin
      ack_min = 0;
      ack_max = $urandom_range(3, 0);
      op      = $urandom_range(3, 0);
      word    = {$urandom, $urandom};
      if (op == 2) begin
        if (CHK == 1 && $urandom_range(4, 0) == 0) begin
          op = $urandom_range(TOTAL - 1, 0);
          mem[op]       = mem[op] ^ 16'h8001;
          model_mem[op] = model_mem[op] ^ 16'h8001;
        end
        applyStimulus(1'b0, 1'b1, word, 1'b0, -1);
      end else begin
        applyStimulus(1'b1, op == 3, word, 1'b1, ($urandom_range(1, 0) == 1) ? 4 : -1);
      end
      idleCheck($urandom_range(2, 1));
    end
    spurious = 1'b0;
    idleCheck(3);

    checkOutput("beat_queue_empty", 64'(exp_beat_q.size()), 64'd0);
    checkOutput("load_queue_empty", 64'(exp_load_q.size()), 64'd0);
    checkOutput("done_queue_empty", 64'(exp_done_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
